bin_stage_sched: RTL and testbench

Sequencer and RAM-port arbiter for the binarization pipeline. It launches the BGR-to-gray stage, waits for it to finish, then launches the threshold/binarize stage. It grants the single shared RAM port to whichever stage currently owns the job phase. It sits between the top-level testbench/host start logic and the two processing stages, and supervises both with a per-stage timeout.

---
 rtl/bin_stage_sched.sv | 138 +++++++++++++
 tb/tb_bin_stage_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_stage_sched.sv
// Sequencer for the gray -> binarize pipeline: launches each stage in turn,
// supervises it with a RUN timeout, and arbitrates the single shared RAM port.
module bin_stage_sched #(
  parameter int TIMEOUT_CYCLES = 2**21,
  parameter int ADDR_WIDTH     = 20,
  parameter int BYTE_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  gray_clr,
  output logic                  gray_start,
  input  logic                  gray_done,
  input  logic                  gray_ren,
  input  logic                  gray_wen,
  input  logic [ADDR_WIDTH-1:0] gray_addr,
  input  logic [BYTE_WIDTH-1:0] gray_d,
  output logic                  bin_clr,
  output logic                  bin_start,
  input  logic                  bin_done,
  input  logic                  bin_ren,
  input  logic                  bin_wen,
  input  logic [ADDR_WIDTH-1:0] bin_addr,
  input  logic [BYTE_WIDTH-1:0] bin_d,
  output logic                  ram_ren,
  output logic                  ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [BYTE_WIDTH-1:0] ram_d,
  output logic                  busy,
  output logic                  job_done,
  output logic                  error,
  output logic                  conflict
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_GRAY_CLR, S_GRAY_START, S_GRAY_RUN,
    S_BIN_CLR, S_BIN_START, S_BIN_RUN, S_DONE, S_ERROR
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          in_run;
  logic          timeout;
  logic          start_ok;
  logic          gray_own;
  logic          bin_own;

  assign in_run   = (state == S_GRAY_RUN) || (state == S_BIN_RUN);
  assign timeout  = (cnt == CNT_LAST);
  assign start_ok = start && !abort && ((state == S_IDLE) || (state == S_ERROR));
  assign gray_own = (state == S_GRAY_CLR) || (state == S_GRAY_START) || (state == S_GRAY_RUN);
  assign bin_own  = (state == S_BIN_CLR) || (state == S_BIN_START) || (state == S_BIN_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Abort outranks everything; within a RUN state done outranks timeout.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_ERROR: if (start) state_nxt = S_GRAY_CLR;
        S_GRAY_CLR:      state_nxt = S_GRAY_START;
        S_GRAY_START:    state_nxt = S_GRAY_RUN;
        S_GRAY_RUN: begin
          if (gray_done)    state_nxt = S_BIN_CLR;
          else if (timeout) state_nxt = S_ERROR;
        end
        S_BIN_CLR:       state_nxt = S_BIN_START;
        S_BIN_START:     state_nxt = S_BIN_RUN;
        S_BIN_RUN: begin
          if (bin_done)     state_nxt = S_DONE;
          else if (timeout) state_nxt = S_ERROR;
        end
        S_DONE:          state_nxt = S_IDLE;
        default:         state_nxt = S_IDLE;
      endcase
    end
  end

  // Held at zero outside RUN, so every RUN entry starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt <= '0;
    else if (!in_run)        cnt <= '0;
    else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_ren  <= 1'b0;
      ram_wen  <= 1'b0;
      ram_addr <= '0;
      ram_d    <= '0;
    end else if (gray_own) begin
      ram_ren  <= gray_ren;
      ram_wen  <= gray_wen;
      ram_addr <= gray_addr;
      ram_d    <= gray_d;
    end else if (bin_own) begin
      ram_ren  <= bin_ren;
      ram_wen  <= bin_wen;
      ram_addr <= bin_addr;
      ram_d    <= bin_d;
    end else begin
      ram_ren  <= 1'b0;
      ram_wen  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      conflict <= 1'b0;
    else if (start_ok)
      conflict <= 1'b0;
    else if (((state == S_GRAY_RUN) && (bin_ren || bin_wen)) ||
             ((state == S_BIN_RUN) && (gray_ren || gray_wen)))
      conflict <= 1'b1;
  end

  assign gray_clr   = (state == S_GRAY_CLR);
  assign gray_start = (state == S_GRAY_START);
  assign bin_clr    = (state == S_BIN_CLR);
  assign bin_start  = (state == S_BIN_START);
  assign job_done   = (state == S_DONE);
  assign error      = (state == S_ERROR);
  assign busy       = (state != S_IDLE) && (state != S_ERROR);

endmodule

// File: tb/tb_bin_stage_sched.sv
// Bench for bin_stage_sched: two instances (timeouts 64 and 16) share stimulus
// and are compared every cycle against a phase/elapsed-time model.
module tb_bin_stage_sched;

  localparam int AW = 20;
  localparam int BW = 8;
  localparam int VW = 10 + AW + BW;

  localparam int P_IDLE = 0, P_GCLR = 1, P_GST = 2, P_GRUN = 3, P_BCLR = 4,
                 P_BST = 5, P_BRUN = 6, P_DONE = 7, P_ERR = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start, abort, gray_done, gray_ren, gray_wen, bin_done, bin_ren, bin_wen;
  logic [AW-1:0] gray_addr, bin_addr;
  logic [BW-1:0] gray_d, bin_d;

  logic a_gray_clr, a_gray_start, a_bin_clr, a_bin_start, a_ram_ren, a_ram_wen;
  logic a_busy, a_job_done, a_error, a_conflict;
  logic [AW-1:0] a_ram_addr;
  logic [BW-1:0] a_ram_d;
  logic b_gray_clr, b_gray_start, b_bin_clr, b_bin_start, b_ram_ren, b_ram_wen;
  logic b_busy, b_job_done, b_error, b_conflict;
  logic [AW-1:0] b_ram_addr;
  logic [BW-1:0] b_ram_d;

  int n_checks = 0;
  int n_errors = 0;
  logic run_cmp = 1'b0;

  always #5 clk = ~clk;

  bin_stage_sched #(.TIMEOUT_CYCLES(64), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW)) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .gray_clr(a_gray_clr), .gray_start(a_gray_start), .gray_done(gray_done),
    .gray_ren(gray_ren), .gray_wen(gray_wen), .gray_addr(gray_addr), .gray_d(gray_d),
    .bin_clr(a_bin_clr), .bin_start(a_bin_start), .bin_done(bin_done),
    .bin_ren(bin_ren), .bin_wen(bin_wen), .bin_addr(bin_addr), .bin_d(bin_d),
    .ram_ren(a_ram_ren), .ram_wen(a_ram_wen), .ram_addr(a_ram_addr), .ram_d(a_ram_d),
    .busy(a_busy), .job_done(a_job_done), .error(a_error), .conflict(a_conflict)
  );

  bin_stage_sched #(.TIMEOUT_CYCLES(16), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW)) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .gray_clr(b_gray_clr), .gray_start(b_gray_start), .gray_done(gray_done),
    .gray_ren(gray_ren), .gray_wen(gray_wen), .gray_addr(gray_addr), .gray_d(gray_d),
    .bin_clr(b_bin_clr), .bin_start(b_bin_start), .bin_done(bin_done),
    .bin_ren(bin_ren), .bin_wen(bin_wen), .bin_addr(bin_addr), .bin_d(bin_d),
    .ram_ren(b_ram_ren), .ram_wen(b_ram_wen), .ram_addr(b_ram_addr), .ram_d(b_ram_d),
    .busy(b_busy), .job_done(b_job_done), .error(b_error), .conflict(b_conflict)
  );

  logic [VW-1:0] act_vec [2];
  assign act_vec[0] = {a_gray_clr, a_gray_start, a_bin_clr, a_bin_start, a_busy,
                       a_job_done, a_error, a_conflict, a_ram_ren, a_ram_wen, a_ram_addr, a_ram_d};
  assign act_vec[1] = {b_gray_clr, b_gray_start, b_bin_clr, b_bin_start, b_busy,
                       b_job_done, b_error, b_conflict, b_ram_ren, b_ram_wen, b_ram_addr, b_ram_d};

  // Behavioural model: job phase plus cycles elapsed in the current RUN phase.
  int            ph [2];
  int            elapsed [2];
  logic          m_conf [2];
  logic          m_ren [2];
  logic          m_wen [2];
  logic [AW-1:0] m_addr [2];
  logic [BW-1:0] m_d [2];

  task automatic model_reset(input int k);
    ph[k] = P_IDLE; elapsed[k] = 0; m_conf[k] = 1'b0;
    m_ren[k] = 1'b0; m_wen[k] = 1'b0; m_addr[k] = '0; m_d[k] = '0;
  endtask

  task automatic model_step(input int k);
    int limit;
    limit = (k == 0) ? 64 : 16;
    if (ph[k] >= P_GCLR && ph[k] <= P_GRUN) begin
      m_ren[k] = gray_ren; m_wen[k] = gray_wen; m_addr[k] = gray_addr; m_d[k] = gray_d;
    end else if (ph[k] >= P_BCLR && ph[k] <= P_BRUN) begin
      m_ren[k] = bin_ren; m_wen[k] = bin_wen; m_addr[k] = bin_addr; m_d[k] = bin_d;
    end else begin
      m_ren[k] = 1'b0; m_wen[k] = 1'b0;
    end
    if (ph[k] == P_GRUN && (bin_ren || bin_wen)) m_conf[k] = 1'b1;
    if (ph[k] == P_BRUN && (gray_ren || gray_wen)) m_conf[k] = 1'b1;
    if (abort) begin
      ph[k] = P_IDLE;
    end else begin
      case (ph[k])
        P_IDLE, P_ERR: if (start) begin ph[k] = P_GCLR; m_conf[k] = 1'b0; end
        P_GCLR: ph[k] = P_GST;
        P_GST:  begin ph[k] = P_GRUN; elapsed[k] = 0; end
        P_GRUN: if (gray_done) ph[k] = P_BCLR;
                else begin elapsed[k]++; if (elapsed[k] == limit) ph[k] = P_ERR; end
        P_BCLR: ph[k] = P_BST;
        P_BST:  begin ph[k] = P_BRUN; elapsed[k] = 0; end
        P_BRUN: if (bin_done) ph[k] = P_DONE;
                else begin elapsed[k]++; if (elapsed[k] == limit) ph[k] = P_ERR; end
        default: ph[k] = P_IDLE;
      endcase
    end
  endtask

  function automatic logic [VW-1:0] exp_vec(input int k);
    return {ph[k] == P_GCLR, ph[k] == P_GST, ph[k] == P_BCLR, ph[k] == P_BST,
            (ph[k] >= P_GCLR && ph[k] <= P_DONE), ph[k] == P_DONE, ph[k] == P_ERR,
            m_conf[k], m_ren[k], m_wen[k], m_addr[k], m_d[k]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset(0); model_reset(1);
    end else begin
      model_step(0); model_step(1);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && run_cmp) begin
      check("model_to64", 64'(act_vec[0]), 64'(exp_vec(0)));
      check("model_to16", 64'(act_vec[1]), 64'(exp_vec(1)));
    end
  end

  task automatic clear_inputs();
    start = 0; abort = 0; gray_done = 0; gray_ren = 0; gray_wen = 0; gray_addr = '0;
    gray_d = '0; bin_done = 0; bin_ren = 0; bin_wen = 0; bin_addr = '0; bin_d = '0;
  endtask

  task automatic cleanup();
    @(negedge clk); clear_inputs(); abort = 1;
    @(negedge clk); abort = 0;
  endtask

  int gclr_t, gst_t, bclr_t, bst_t, jd_t, bfall_t, jd_cnt, err_t;

  initial begin
    clear_inputs();
    rst = 1;
    repeat (3) @(negedge clk);
    check("reset_to64", 64'(act_vec[0]), 64'd0);
    check("reset_to16", 64'(act_vec[1]), 64'd0);
    rst = 0;
    run_cmp = 1;

    // Normal job with stray starts at 5 and 25.
    gclr_t = -1; gst_t = -1; bclr_t = -1; bst_t = -1; jd_t = -1; bfall_t = -1; jd_cnt = 0;
    for (int t = 0; t < 46; t++) begin
      @(negedge clk);
      if (a_gray_clr && gclr_t < 0) gclr_t = t;
      if (a_gray_start && gst_t < 0) gst_t = t;
      if (a_bin_clr && bclr_t < 0) bclr_t = t;
      if (a_bin_start && bst_t < 0) bst_t = t;
      if (a_job_done && jd_t < 0) jd_t = t;
      if (a_job_done) jd_cnt++;
      if (!a_busy && t > 1 && bfall_t < 0) bfall_t = t;
      start = (t == 0 || t == 5 || t == 25);
      gray_done = (t >= 20);
      bin_done = (t >= 40);
    end
    check("gray_clr_cycle", gclr_t, 1);
    check("gray_start_cycle", gst_t, 2);
    check("bin_clr_cycle", bclr_t, 21);
    check("bin_start_cycle", bst_t, 22);
    check("job_done_cycle", jd_t, 41);
    check("busy_fall_cycle", bfall_t, 42);
    check("job_done_count", jd_cnt, 1);
    cleanup();

    // Timeout on the 16-cycle instance, then restart out of ERROR.
    err_t = -1;
    for (int t = 0; t < 23; t++) begin
      @(negedge clk);
      if (b_error && err_t < 0) err_t = t;
      if (t == 21) begin
        check("restart_error_clear", b_error, 0);
        check("restart_gray_clr", b_gray_clr, 1);
      end
      start = (t == 0 || t == 20);
    end
    check("timeout_cycle", err_t, 19);
    cleanup();

    // Abort in GRAY_RUN with gray writing.
    jd_cnt = 0;
    for (int t = 0; t < 15; t++) begin
      @(negedge clk);
      if (a_job_done) jd_cnt++;
      if (t == 11) begin
        check("abort_busy", a_busy, 0);
        check("abort_last_wen", a_ram_wen, 1);
      end
      if (t == 12) check("abort_wen_drop", a_ram_wen, 0);
      start = (t == 0);
      abort = (t == 10);
      gray_wen = (t >= 3 && t <= 10);
      gray_addr = 20'h00100 + AW'(t);
    end
    check("abort_no_job_done", jd_cnt, 0);
    cleanup();

    // Arbitration: both stages write in GRAY_RUN, gray must win.
    for (int t = 0; t < 11; t++) begin
      @(negedge clk);
      if (t == 6) begin
        check("arb_wen", a_ram_wen, 1);
        check("arb_addr", a_ram_addr, 20'h00010);
        check("arb_d", a_ram_d, 8'h5A);
        check("arb_conflict", a_conflict, 1);
      end
      if (t == 10) check("conflict_sticky", a_conflict, 1);
      start = (t == 0);
      gray_wen = (t == 5); gray_addr = (t == 5) ? 20'h00010 : '0; gray_d = (t == 5) ? 8'h5A : '0;
      bin_wen = (t == 5);  bin_addr = (t == 5) ? 20'h00020 : '0;  bin_d = (t == 5) ? 8'h33 : '0;
    end
    cleanup();

    // bin_done arrives on the cycle the 16-cycle counter reaches its last value.
    for (int t = 0; t < 25; t++) begin
      @(negedge clk);
      if (t == 23) begin
        check("simul_job_done", b_job_done, 1);
        check("simul_error", b_error, 0);
      end
      if (t == 24) check("simul_idle_error", b_error, 0);
      start = (t == 0);
      gray_done = (t == 4);
      bin_done = (t == 22);
    end
    cleanup();

    // Asynchronous reset in the middle of a job.
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      start = (t == 0);
      gray_ren = 1; gray_addr = 20'hABCDE; gray_d = 8'hC3;
    end
    @(negedge clk);
    rst = 1;
    #1;
    check("async_reset_to64", 64'(act_vec[0]), 64'd0);
    check("async_reset_to16", 64'(act_vec[1]), 64'd0);
    @(negedge clk);
    clear_inputs();
    rst = 0;

    // Randomised traffic, first with frequent dones, then sparse ones.
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      start     = ($urandom_range(0, 5) == 0);
      abort     = ($urandom_range(0, 99) == 0);
      gray_done = (t < 2000) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 39) == 0);
      bin_done  = (t < 2000) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 39) == 0);
      gray_ren  = 1'($urandom_range(0, 1));
      gray_wen  = 1'($urandom_range(0, 1));
      bin_ren   = ($urandom_range(0, 7) == 0);
      bin_wen   = ($urandom_range(0, 7) == 0);
      gray_addr = AW'($urandom);
      bin_addr  = AW'($urandom);
      gray_d    = BW'($urandom);
      bin_d     = BW'($urandom);
    end
    @(negedge clk);
    run_cmp = 0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
